// File: rtl/hex_scan_display_if.sv
// Display-side bundle for hex_scan_display: result word, control strobes and
// the static and scanned segment/enable outputs.
interface hex_scan_display_if #(
    parameter int DIGITS = 8
) ();
    logic [4*DIGITS-1:0] value;
    logic                load;
    logic                blank_lz;
    logic                blink_en;
    logic [7*DIGITS-1:0] seg_all;
    logic [6:0]          scan_seg;
    logic [DIGITS-1:0]   digit_en;
    logic                frame_tick;

    modport master (
        output value, load, blank_lz, blink_en,
        input  seg_all, scan_seg, digit_en, frame_tick
    );

    modport slave (
        input  value, load, blank_lz, blink_en,
        output seg_all, scan_seg, digit_en, frame_tick
    );
endinterface

// File: rtl/hex_scan_display.sv
// Hex display driver: snapshots a result word and drives static per-digit
// segments plus a scanned bus with leading-zero blanking and blink.
module hex_scan_display #(
    parameter int DIGITS         = 8,
    parameter int SCAN_DIV       = 50000,
    parameter int BLINK_FRAMES   = 64,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    hex_scan_display_if.slave  bus
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);
    localparam logic [FW-1:0] FRM_MAX   = FW'(BLINK_FRAMES - 1);

    // Codes are built active-low; XOR with POL flips them for active-high pins.
    localparam logic [6:0] POL   = SEG_ACTIVE_LOW ? 7'h00 : 7'h7f;
    localparam logic [6:0] BLANK = 7'h7f ^ POL;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'h0: code = 7'b0000001;
            4'h1: code = 7'b1001111;
            4'h2: code = 7'b0010010;
            4'h3: code = 7'b0000110;
            4'h4: code = 7'b1001100;
            4'h5: code = 7'b0100100;
            4'h6: code = 7'b0100000;
            4'h7: code = 7'b0001111;
            4'h8: code = 7'b0000000;
            4'h9: code = 7'b0001100;
            4'ha: code = 7'b0001000;
            4'hb: code = 7'b1100000;
            4'hc: code = 7'b0110001;
            4'hd: code = 7'b1000010;
            4'he: code = 7'b0110000;
            default: code = 7'b0111000;
        endcase
        return code;
    endfunction

    logic [4*DIGITS-1:0] snap_q, snap_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [FW-1:0]       frame_q, frame_d;
    logic                phase_q, phase_d;
    logic                wrap_q, wrap_d;

    logic [7*DIGITS-1:0] seg_all_q, seg_all_d;
    logic [6:0]          scan_seg_q, scan_seg_d;
    logic [DIGITS-1:0]   digit_en_q, digit_en_d;
    logic                frame_tick_q, frame_tick_d;

    logic                presc_wrap;
    logic                idx_wrap;
    logic                visible;
    logic                zero_above;

    // NOTE: every signal gets a default at the top of always_comb; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        snap_d       = bus.load ? bus.value : snap_q;
        presc_wrap   = (presc_q == PRESC_MAX);
        idx_wrap     = presc_wrap && (idx_q == IDX_MAX);
        presc_d      = presc_wrap ? '0 : presc_q + PW'(1);
        idx_d        = idx_q;
        frame_d      = frame_q;
        phase_d      = phase_q;
        wrap_d       = idx_wrap;
        frame_tick_d = wrap_q;
        seg_all_d    = '0;
        scan_seg_d   = BLANK;
        digit_en_d   = '0;
        zero_above   = 1'b1;

        if (presc_wrap) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
        end

        if (idx_wrap) begin
            if (frame_q == FRM_MAX) begin
                frame_d = '0;
                phase_d = ~phase_q;
            end else begin
                frame_d = frame_q + FW'(1);
            end
        end

        visible = !(bus.blink_en && !phase_q);

        // Walk from the most significant digit so zero_above covers nibbles DIGITS-1..i.
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (snap_q[4*i +: 4] == 4'h0);
            if (!visible || (bus.blank_lz && (i > 0) && zero_above)) begin
                seg_all_d[7*i +: 7] = BLANK;
            end else begin
                seg_all_d[7*i +: 7] = decode(snap_q[4*i +: 4]) ^ POL;
            end
        end

        for (int i = 0; i < DIGITS; i++) begin
            digit_en_d[i] = (idx_q == IW'(i));
            if (idx_q == IW'(i)) begin
                scan_seg_d = seg_all_d[7*i +: 7];
            end
        end
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_q       <= '0;
            presc_q      <= '0;
            idx_q        <= '0;
            frame_q      <= '0;
            phase_q      <= 1'b1;
            wrap_q       <= 1'b0;
            seg_all_q    <= {DIGITS{BLANK}};
            scan_seg_q   <= BLANK;
            digit_en_q   <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            snap_q       <= snap_d;
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            frame_q      <= frame_d;
            phase_q      <= phase_d;
            wrap_q       <= wrap_d;
            seg_all_q    <= seg_all_d;
            scan_seg_q   <= scan_seg_d;
            digit_en_q   <= digit_en_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign bus.seg_all    = seg_all_q;
    assign bus.scan_seg   = scan_seg_q;
    assign bus.digit_en   = digit_en_q;
    assign bus.frame_tick = frame_tick_q;
endmodule

// File: doc/hex_scan_display.md
# hex_scan_display

Parametrised hexadecimal display driver that succeeds the fixed 8-digit static decoder. It captures a `4*DIGITS`-bit result word on a load strobe and drives two things from that snapshot: static per-digit segment buses, and a time-multiplexed single segment bus with one-hot digit enables for scanned displays. It adds leading-zero blanking, a selectable blink mode, segment polarity selection and a frame tick. It sits between the datapath result (ALU/register readout) and the board display pins.

## Interface
- `DIGITS`, 8, number of hex digits (1..16); the input word is `4*DIGITS` bits wide.
- `SCAN_DIV`, 50000, clock cycles each digit is enabled in scan mode (>=2).
- `BLINK_FRAMES`, 64, full scan frames per blink half-period (>=1).
- `SEG_ACTIVE_LOW`, 1, 1: segment lit = 0; 0: segment lit = 1.
- `clk`  in  1  single clock; every register updates on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `value`  in  4*DIGITS  word to display; nibble i maps to digit i.
- `load`  in  1  strobe that captures `value` into the snapshot at the rising edge where it is high.
- `blank_lz`  in  1  enables leading-zero blanking.
- `blink_en`  in  1  enables blinking.
- `seg_all`  out  7*DIGITS  static segments; digit i occupies [7i+6:7i], with segment a at bit 7i+6 and g at bit 7i.
- `scan_seg`  out  7  segments (a..g, MSB-first) of the currently enabled digit.
- `digit_en`  out  DIGITS  one-hot active-high enable for the scanned digit.
- `frame_tick`  out  1  one-cycle pulse when the scan index wraps from DIGITS-1 to 0.

## Operation
- **Snapshot register `snap`:**
  - reset value 0;
  - loads `value` when `load`=1;
  - otherwise holds.
- **Active-low decode table (a..g), 0..F:**
  - 0000001, 1001111, 0010010, 0000110;
  - 1001100, 0100100, 0100000, 0001111;
  - 0000000, 0001100, 0001000, 1100000;
  - 0110001, 1000010, 0110000, 0111000.
- **Blank code:** 1111111.
- **Polarity:** with `SEG_ACTIVE_LOW`=0, every code, including blank, is bitwise inverted.
- **Leading-zero blanking** (`blank_lz`=1):
  - A digit i>0 is blanked when snap nibbles DIGITS-1 down to i are all zero.
  - Digit 0 is never blanked by this rule, so a snapshot of 0 shows a single "0".
- **Scan logic:**
  - Prescaler counts 0..SCAN_DIV-1 and wraps.
  - On the wrap, index advances by 1; from DIGITS-1 it wraps to 0.
  - `digit_en` = one-hot of index; `scan_seg` = decoded/blanked code of digit index.
  - `digit_en` and `scan_seg` always describe the same digit in the same cycle.
- **Blink logic:**
  - Frame counter counts `frame_tick` events 0..BLINK_FRAMES-1.
  - On its wrap, `phase` toggles; `phase` resets to 1 (visible).
  - The counters run regardless of `blink_en`.
  - When `blink_en`=1 and `phase`=0, all `seg_all` digits and `scan_seg` show the blank code. `digit_en` keeps scanning.
- `load` has no effect on the prescaler, index or blink state.

## Timing
- **Reset values:**
  - `snap`=0, prescaler=0, index=0, frame counter=0, `phase`=1;
  - `seg_all` = all digits blank code, `scan_seg` = blank code;
  - `digit_en`=0, `frame_tick`=0.
- **Output registering:** all outputs are registered and computed from the state held before the edge. Output latency is 1 cycle behind state.
- **Load latency:** `load` sampled at edge N updates `snap` at N; `seg_all` reflects the new word after edge N+1.
- **`blank_lz` / `blink_en`:** both are sampled every cycle and take effect on outputs after 1 edge.
- **First cycle after reset release:**
  - `digit_en` = 1 (digit 0);
  - `seg_all` shows snapshot 0, which is "0" on every digit, or only digit 0 with blanking.
- **Digit dwell:** each digit is enabled for exactly SCAN_DIV cycles; one frame is `DIGITS*SCAN_DIV` cycles.
- **`frame_tick`:** high for the single cycle in which `digit_en` returns to digit 0.
- **Simultaneous `rst` and `load`:** reset wins and `snap`=0.
- **Reset mid-scan:** outputs return to their reset values after that edge, and the scan restarts at digit 0.

## Test plan
- **Load, no blanking:** DIGITS=8, `blank_lz`=0; load 32'h01234567.
  - Two edges after `load`: digit0 = 0001111, digit1 = 0100000, digit7 = 0000001.
- **Leading-zero blanking:** `blank_lz`=1.
  - Load 32'h000000A0: digits 7..2 = 1111111, digit1 = 0001000, digit0 = 0000001.
  - Load 0: only digit0 = 0000001.
- **Scan sequence:** SCAN_DIV=4.
  - `digit_en` steps 0x01, 0x02, ..., 0x80, 0x01, changing every 4 cycles.
  - `frame_tick` pulses once per 32 cycles.
  - `scan_seg` equals the `seg_all` field of the enabled digit in every cycle.
- **Blink:** BLINK_FRAMES=2, SCAN_DIV=4, `blink_en`=1.
  - Display is visible for 64 cycles, then all blank for 64 cycles, repeating.
  - Deasserting `blink_en` while blanked restores the display after 1 edge.
- **Mid-frame load and reset:**
  - A load at the 3rd cycle of digit 5's dwell changes `scan_seg` after 1 edge without moving `digit_en`.
  - `rst` asserted mid-frame gives `digit_en`=0 and blank outputs after 1 edge, then digit 0 after release.
- **Polarity:** `SEG_ACTIVE_LOW`=0; load 32'h8.
  - digit0 = 1111111.
  - With `blank_lz`=1, digits 7..1 = 0000000.
